// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit: ID-stage fields in, EX mux selects and stall controls out.
// With HAZARD_STATS_EN defined, the bundle also carries the stall/forward event counters.
interface forwarding_hazard_unit_if #(
   parameter int REG_ADDR_W = 5
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  flush;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  stall;
   logic                  ex_bubble;
`ifdef HAZARD_STATS_EN
   logic [15:0]           stall_count;
   logic [15:0]           fwd_count;
`endif

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush,
      input  fwd_a_sel, fwd_b_sel, stall, ex_bubble
`ifdef HAZARD_STATS_EN
      , input stall_count, fwd_count
`endif
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush,
      output fwd_a_sel, fwd_b_sel, stall, ex_bubble
`ifdef HAZARD_STATS_EN
      , output stall_count, fwd_count
`endif
   );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// EX-stage forwarding selects and load-use stall/bubble generation from shadow copies of EX/MEM/WB state.
// Optional macro HAZARD_STATS_EN adds saturating stall_count and fwd_count outputs on the interface.
module forwarding_hazard_unit #(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_STALLS = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   forwarding_hazard_unit_if.slave  hz
);
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic                  usesRt;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regWrite;
      logic                  memRead;
   } exShadow_t;

   // Past EX only the destination side matters, so MEM and WB keep fewer fields.
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regWrite;
      logic                  memRead;
   } memShadow_t;

   exShadow_t             exShadow_d;
   exShadow_t             exShadow_q;
   memShadow_t            memShadow_q;
   logic                  wbValid_q;
   logic                  wbRegWrite_q;
   logic [REG_ADDR_W-1:0] wbRd_q;

   logic                  memWrites;
   logic                  wbWrites;
   logic [1:0]            fwdA;
   logic [1:0]            fwdB;
   logic                  hazardEx;
   logic                  hazardMem;
   logic                  stallNow;
   logic                  bubbleNow;

   // MEM is the younger producer, so it wins over WB when both write the same register.
   always_comb begin
      memWrites = memShadow_q.valid && memShadow_q.regWrite && (memShadow_q.rd != '0);
      wbWrites  = wbValid_q && wbRegWrite_q && (wbRd_q != '0);
      fwdA      = 2'b00;
      fwdB      = 2'b00;
      if (memWrites && memShadow_q.rd == exShadow_q.rs)
         fwdA = 2'b10;
      else if (wbWrites && wbRd_q == exShadow_q.rs)
         fwdA = 2'b01;
      if (exShadow_q.usesRt) begin
         if (memWrites && memShadow_q.rd == exShadow_q.rt)
            fwdB = 2'b10;
         else if (wbWrites && wbRd_q == exShadow_q.rt)
            fwdB = 2'b01;
      end
   end

   // A taken branch kills the dependent instruction, so flush suppresses the stall.
   always_comb begin
      hazardEx  = hz.id_valid && exShadow_q.valid && exShadow_q.memRead && (exShadow_q.rd != '0) &&
                  ((exShadow_q.rd == hz.id_rs) || (hz.id_uses_rt && exShadow_q.rd == hz.id_rt));
      hazardMem = hz.id_valid && memShadow_q.valid && memShadow_q.memRead && (memShadow_q.rd != '0) &&
                  ((memShadow_q.rd == hz.id_rs) || (hz.id_uses_rt && memShadow_q.rd == hz.id_rt));
      stallNow  = (hazardEx || ((LOAD_USE_STALLS == 2) && hazardMem)) && !hz.flush;
      bubbleNow = stallNow || hz.flush;
   end

   // Bubbles and empty ID slots enter EX as all-zero records so stale addresses never match.
   always_comb begin
      exShadow_d = '0;
      if (!bubbleNow && hz.id_valid) begin
         exShadow_d.valid    = 1'b1;
         exShadow_d.rs       = hz.id_rs;
         exShadow_d.rt       = hz.id_rt;
         exShadow_d.usesRt   = hz.id_uses_rt;
         exShadow_d.rd       = hz.id_rd;
         exShadow_d.regWrite = hz.id_reg_write;
         exShadow_d.memRead  = hz.id_mem_read;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exShadow_q   <= '0;
         memShadow_q  <= '0;
         wbValid_q    <= 1'b0;
         wbRegWrite_q <= 1'b0;
         wbRd_q       <= '0;
      end else begin
         wbValid_q            <= memShadow_q.valid;
         wbRegWrite_q         <= memShadow_q.regWrite;
         wbRd_q               <= memShadow_q.rd;
         memShadow_q.valid    <= exShadow_q.valid;
         memShadow_q.rd       <= exShadow_q.rd;
         memShadow_q.regWrite <= exShadow_q.regWrite;
         memShadow_q.memRead  <= exShadow_q.memRead;
         exShadow_q           <= exShadow_d;
      end
   end

   assign hz.fwd_a_sel = fwdA;
   assign hz.fwd_b_sel = fwdB;
   assign hz.stall     = stallNow;
   assign hz.ex_bubble = bubbleNow;

`ifdef HAZARD_STATS_EN
   logic [15:0] stallCount_q;
   logic [15:0] fwdCount_q;

   // Event counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCount_q <= 16'd0;
         fwdCount_q   <= 16'd0;
      end else begin
         if (stallNow && stallCount_q != 16'hFFFF)
            stallCount_q <= stallCount_q + 16'd1;
         if ((fwdA != 2'b00 || fwdB != 2'b00) && fwdCount_q != 16'hFFFF)
            fwdCount_q <= fwdCount_q + 16'd1;
      end
   end

   assign hz.stall_count = stallCount_q;
   assign hz.fwd_count   = fwdCount_q;
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: one instance per legal LOAD_USE_STALLS value, driven with identical
// ID streams and compared against an instruction-level pipeline model every cycle.
module tb_forwarding_hazard_unit;
   localparam int W = 5;

   typedef struct {
      bit v;
      int rs;
      int rt;
      bit ur;
      int rd;
      bit rw;
      bit mr;
   } instRec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   forwarding_hazard_unit_if #(.REG_ADDR_W(W)) ifA ();
   forwarding_hazard_unit_if #(.REG_ADDR_W(W)) ifB ();

   forwarding_hazard_unit #(.REG_ADDR_W(W), .LOAD_USE_STALLS(1)) dutA (.clk(clk), .rst_n(rst_n), .hz(ifA));
   forwarding_hazard_unit #(.REG_ADDR_W(W), .LOAD_USE_STALLS(2)) dutB (.clk(clk), .rst_n(rst_n), .hz(ifB));

   // stage[k][0..2] = instruction currently in EX, MEM, WB for instance k (k+1 load-use stalls).
   instRec_t stage [2][3];
   instRec_t idInst;
   bit       idFlush;
   bit [1:0] expA [2];
   bit [1:0] expB [2];
   bit       expStall [2];
   bit       expBub [2];
   int       stallCnt [2];
   int       fwdCnt [2];
   int       passCount = 0;
   int       failCount = 0;
   int       checkCount = 0;

   function automatic instRec_t mkInst(bit v, int rs, int rt, bit ur, int rd, bit rw, bit mr);
      instRec_t r;
      r.v = v; r.rs = rs; r.rt = rt; r.ur = ur; r.rd = rd; r.rw = rw; r.mr = mr;
      return r;
   endfunction

   task automatic resetModel();
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 3; s++) stage[k][s] = mkInst(0, 0, 0, 0, 0, 0, 0);
         stallCnt[k] = 0;
         fwdCnt[k]   = 0;
      end
   endtask

   // Nearest older writer of src wins; its distance from EX picks the code (MEM=2, WB=1).
   function automatic bit [1:0] producerCode(int k, int src);
      for (int s = 1; s <= 2; s++)
         if (stage[k][s].v && stage[k][s].rw && stage[k][s].rd != 0 && stage[k][s].rd == src)
            return 2'(3 - s);
      return 2'b00;
   endfunction

   task automatic computeExpected();
      for (int k = 0; k < 2; k++) begin
         bit haz = 0;
         expA[k] = producerCode(k, stage[k][0].rs);
         expB[k] = stage[k][0].ur ? producerCode(k, stage[k][0].rt) : 2'b00;
         for (int s = 0; s <= k; s++)
            if (idInst.v && stage[k][s].mr && stage[k][s].rd != 0 &&
                (stage[k][s].rd == idInst.rs || (idInst.ur && stage[k][s].rd == idInst.rt)))
               haz = 1;
         expStall[k] = haz && !idFlush;
         expBub[k]   = expStall[k] || idFlush;
      end
   endtask

   task automatic checkEq(string tag, int k, logic [15:0] obs, logic [15:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic applyStimulus(instRec_t r, bit fl);
      idInst  = r;
      idFlush = fl;
      ifA.id_valid = r.v;  ifA.id_rs = r.rs[W-1:0]; ifA.id_rt = r.rt[W-1:0]; ifA.id_uses_rt = r.ur;
      ifA.id_rd = r.rd[W-1:0]; ifA.id_reg_write = r.rw; ifA.id_mem_read = r.mr; ifA.flush = fl;
      ifB.id_valid = r.v;  ifB.id_rs = r.rs[W-1:0]; ifB.id_rt = r.rt[W-1:0]; ifB.id_uses_rt = r.ur;
      ifB.id_rd = r.rd[W-1:0]; ifB.id_reg_write = r.rw; ifB.id_mem_read = r.mr; ifB.flush = fl;
   endtask

   task automatic checkOutput();
      computeExpected();
      checkEq("fwdA", 0, 16'(ifA.fwd_a_sel), 16'(expA[0]));
      checkEq("fwdB", 0, 16'(ifA.fwd_b_sel), 16'(expB[0]));
      checkEq("stall", 0, 16'(ifA.stall), 16'(expStall[0]));
      checkEq("bubble", 0, 16'(ifA.ex_bubble), 16'(expBub[0]));
      checkEq("fwdA", 1, 16'(ifB.fwd_a_sel), 16'(expA[1]));
      checkEq("fwdB", 1, 16'(ifB.fwd_b_sel), 16'(expB[1]));
      checkEq("stall", 1, 16'(ifB.stall), 16'(expStall[1]));
      checkEq("bubble", 1, 16'(ifB.ex_bubble), 16'(expBub[1]));
`ifdef HAZARD_STATS_EN
      checkEq("stallCount", 0, ifA.stall_count, 16'(stallCnt[0]));
      checkEq("fwdCount", 0, ifA.fwd_count, 16'(fwdCnt[0]));
      checkEq("stallCount", 1, ifB.stall_count, 16'(stallCnt[1]));
      checkEq("fwdCount", 1, ifB.fwd_count, 16'(fwdCnt[1]));
`endif
   endtask

   task automatic advanceModel();
      for (int k = 0; k < 2; k++) begin
         if (expStall[k] && stallCnt[k] < 65535) stallCnt[k]++;
         if ((expA[k] != 0 || expB[k] != 0) && fwdCnt[k] < 65535) fwdCnt[k]++;
         stage[k][2] = stage[k][1];
         stage[k][1] = stage[k][0];
         stage[k][0] = (expBub[k] || !idInst.v) ? mkInst(0, 0, 0, 0, 0, 0, 0) : idInst;
      end
   endtask

   task automatic drive(bit v, int rs, int rt, bit ur, int rd, bit rw, bit mr, bit fl);
      @(negedge clk);
      applyStimulus(mkInst(v, rs, rt, ur, rd, rw, mr), fl);
      #1;
      checkOutput();
   endtask

   task automatic clockEdge();
      @(posedge clk);
      advanceModel();
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(mkInst(0, 0, 0, 0, 0, 0, 0), 0);
      resetModel();
      #1;
      checkOutput();
      @(posedge clk);
      #2 rst_n = 1'b1;

      // add r3 then sub r4,r3,r5: sub sees r3 from MEM.
      drive(1, 1, 2, 1, 3, 1, 0, 0); clockEdge();
      drive(1, 3, 5, 1, 4, 1, 0, 0); clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checkEq("exexFwdA", 0, 16'(ifA.fwd_a_sel), 16'h2);
      checkEq("exexFwdB", 0, 16'(ifA.fwd_b_sel), 16'h0);
      clockEdge();

      // r7 written by both MEM and WB, then only by WB.
      drive(1, 0, 0, 0, 7, 1, 0, 0); clockEdge();
      drive(1, 0, 0, 0, 7, 1, 0, 0); clockEdge();
      drive(1, 7, 1, 0, 9, 1, 0, 0); clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checkEq("memPriority", 0, 16'(ifA.fwd_a_sel), 16'h2);
      clockEdge();
      drive(1, 0, 0, 0, 7, 1, 0, 0); clockEdge();
      drive(1, 0, 0, 0, 8, 1, 0, 0); clockEdge();
      drive(1, 7, 1, 0, 9, 1, 0, 0); clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checkEq("wbFwd", 0, 16'(ifA.fwd_a_sel), 16'h1);
      clockEdge();

      drive(1, 1, 1, 0, 0, 1, 0, 0); clockEdge();
      drive(1, 0, 0, 1, 5, 1, 0, 0); clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checkEq("r0FwdA", 0, 16'(ifA.fwd_a_sel), 16'h0);
      checkEq("r0FwdB", 0, 16'(ifA.fwd_b_sel), 16'h0);
      clockEdge();

      // lw r2 then add r6,r2,r2, held in ID while stalled.
      drive(1, 1, 0, 0, 2, 1, 1, 0); clockEdge();
      drive(1, 2, 2, 1, 6, 1, 0, 0);
      checkEq("luStall1", 0, 16'(ifA.stall), 16'h1);
      checkEq("luBubble1", 0, 16'(ifA.ex_bubble), 16'h1);
      checkEq("luStall1", 1, 16'(ifB.stall), 16'h1);
      clockEdge();
      drive(1, 2, 2, 1, 6, 1, 0, 0);
      checkEq("luStall2", 0, 16'(ifA.stall), 16'h0);
      checkEq("luStall2", 1, 16'(ifB.stall), 16'h1);
      clockEdge();
      drive(1, 2, 2, 1, 6, 1, 0, 0);
      checkEq("luWbFwdA", 0, 16'(ifA.fwd_a_sel), 16'h1);
      checkEq("luWbFwdB", 0, 16'(ifA.fwd_b_sel), 16'h1);
      checkEq("luStall3", 1, 16'(ifB.stall), 16'h0);
      clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checkEq("luRegfileA", 1, 16'(ifB.fwd_a_sel), 16'h0);
      clockEdge();

      drive(1, 1, 0, 0, 2, 1, 1, 0); clockEdge();
      drive(1, 2, 3, 1, 6, 1, 0, 1);
      checkEq("flushStall", 0, 16'(ifA.stall), 16'h0);
      checkEq("flushBubble", 0, 16'(ifA.ex_bubble), 16'h1);
      clockEdge();
      drive(1, 6, 6, 1, 4, 1, 0, 0); clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0); clockEdge();

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 7) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
         clockEdge();
      end

      // Asynchronous reset while a load-use stall is active.
      drive(1, 1, 0, 0, 2, 1, 1, 0); clockEdge();
      drive(1, 2, 2, 1, 6, 1, 0, 0);
      checkEq("preResetStall", 0, 16'(ifA.stall), 16'h1);
      #1 rst_n = 1'b0;
      #1;
      resetModel();
      checkOutput();
      checkEq("resetStall", 0, 16'(ifA.stall), 16'h0);
      checkEq("resetStall", 1, 16'(ifB.stall), 16'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1, 2, 2, 1, 6, 1, 0, 0); clockEdge();
      drive(0, 0, 0, 0, 0, 0, 0, 0); clockEdge();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
